conv_sched: RTL and testbench
=============================

CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 SHALL have parameter IMG_W, default 28, input feature map width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28, input feature map height in pixels.
REQ-003 SHALL have parameter K, default 5, square kernel side; the attached PE is built with PERIOD = K*K.
REQ-004 SHALL have parameter ADDR_W, default 10, inmap address width; ADDR_W >= clog2(IMG_W*IMG_H).
REQ-005 SHALL have ports:
  clk  in  1  clock, rising edge
  rst  in  1  reset, asynchronous, active-high
  start  in  1  one-cycle pulse, begins a full-map pass
  cfg_bias  in  8  signed Q4.3 bias, latched on accepted start
  busy  out  1  high from accepted start until done
  done  out  1  one-cycle pulse at end of pass
  err  out  1  sticky PE-alignment error
  in_rd  out  1  inmap RAM read enable
  in_addr  out  ADDR_W  inmap RAM address
  in_data  in  8  inmap RAM data, valid 1 cycle after in_rd
  w_rd  out  1  weight RAM read enable
  w_addr  out  clog2(K*K)  weight RAM address
  w_data  in  8  weight RAM data, valid 1 cycle after w_rd
  pe_inmap  out  8  to PE inmap
  pe_weight  out  8  to PE weight
  pe_vld  out  1  to PE inmap_vld and weight_vld
  pe_bias  out  8  to PE bias
  pe_outmap  in  8  from PE outmap
  pe_outmap_vld  in  1  from PE outmap_vld
  out_data  out  8  activated output pixel
  out_idx  out  ADDR_W  output pixel index oy*(IMG_W-K+1)+ox
  out_valid  out  1  output handshake valid
  out_ready  in  1  output handshake ready

Function
REQ-006 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-007 IDLE: start=1 -> latch cfg_bias, clear tap/window counters, go RUN; start in any other state SHALL be ignored.
REQ-008 RUN: each issue cycle SHALL assert in_rd and w_rd together with in_addr=(oy+ky)*IMG_W+(ox+kx), w_addr=ky*K+kx.
REQ-009 Tap order SHALL be kx fastest then ky; window order ox fastest then oy; ox in 0..IMG_W-K, oy in 0..IMG_H-K.
REQ-010 pe_vld SHALL equal the in_rd value of the previous cycle; pe_inmap=in_data, pe_weight=w_data (1-cycle latency).
REQ-011 pe_bias SHALL equal the latched bias during the whole pass.
REQ-012 Issue of tap K*K-1 SHALL occur only if out_valid=0 or (out_valid & out_ready) in that cycle; otherwise in_rd=w_rd=0 (stall, counters hold).
REQ-013 No other tap SHALL stall; taps issue back-to-back.
REQ-014 When pe_vld & pe_outmap_vld: out_data<=pe_outmap, out_idx<=current window index, out_valid<=1 next edge.
REQ-015 out_valid SHALL clear on out_valid & out_ready unless a new capture occurs the same edge (capture wins).
REQ-016 out_data/out_idx SHALL hold stable while out_valid & !out_ready.
REQ-017 After the last tap of the last window is issued: go DRAIN; DRAIN exits to DONE once last result is captured and accepted.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE; busy=0 in IDLE and DONE.
REQ-019 err SHALL set if pe_vld & pe_outmap_vld occur on a tap index other than K*K-1, or pe_vld & tap K*K-1 without pe_outmap_vld; cleared only by rst.
REQ-020 Counters SHALL wrap: kx K-1->0 increments ky; ky K-1->0 increments ox; ox IMG_W-K->0 increments oy.
REQ-021 Total pe_vld cycles per pass SHALL equal (IMG_W-K+1)*(IMG_H-K+1)*K*K exactly.

Reset
REQ-022 rst=1 SHALL asynchronously force IDLE, all counters 0, bias 0, busy=done=err=0, in_rd=w_rd=pe_vld=0, out_valid=0, out_data=out_idx=in_addr=w_addr=0.
REQ-023 rst mid-pass SHALL abort without done; the PE shares rst so its counter realigns.

Verification
REQ-024 IMG_W=IMG_H=6, K=5, all inmap=0x08, all weights=0x01, bias 0, out_ready=1 -> 4 outputs of 0x19, out_idx 0,1,2,3, 100 pe_vld cycles, done once, err=0.
REQ-025 Same, out_ready=0 for 30 cycles after first out_valid -> out_data/out_idx held, in_rd low at tap 24 of window 1, no output lost or duplicated.
REQ-026 Same, bias=0xF0 (-2.0) -> outputs 0x09 (1.125).
REQ-027 start pulsed again while busy -> ignored, sequence identical to REQ-024.
REQ-028 rst asserted after 40 taps, then new start -> clean pass matching REQ-024, err=0.
REQ-029 Inmap ramp in_data=addr[7:0], weight one-hot at tap 12 (0x08) -> out_data equals centre pixel per window (14,15,20,21 for 6x6).

Source files
------------

// File: rtl/conv_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_sched_if
// Brief    : Control, RAM-read, PE and output-stream signals of conv_sched.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_sched_if #(
    parameter int ADDR_W = 10,
    parameter int K      = 5
);
    localparam int c_WA_W = $clog2(K * K);

    logic                start;
    logic [7:0]          cfg_bias;
    logic                busy;
    logic                done;
    logic                err;

    logic                in_rd;
    logic [ADDR_W-1:0]   in_addr;
    logic [7:0]          in_data;
    logic                w_rd;
    logic [c_WA_W-1:0]   w_addr;
    logic [7:0]          w_data;

    logic [7:0]          pe_inmap;
    logic [7:0]          pe_weight;
    logic                pe_vld;
    logic [7:0]          pe_bias;
    logic [7:0]          pe_outmap;
    logic                pe_outmap_vld;

    logic [7:0]          out_data;
    logic [ADDR_W-1:0]   out_idx;
    logic                out_valid;
    logic                out_ready;

    modport master (
        input  start, cfg_bias, in_data, w_data, pe_outmap, pe_outmap_vld, out_ready,
        output busy, done, err, in_rd, in_addr, w_rd, w_addr,
               pe_inmap, pe_weight, pe_vld, pe_bias, out_data, out_idx, out_valid
    );

    modport slave (
        output start, cfg_bias, in_data, w_data, pe_outmap, pe_outmap_vld, out_ready,
        input  busy, done, err, in_rd, in_addr, w_rd, w_addr,
               pe_inmap, pe_weight, pe_vld, pe_bias, out_data, out_idx, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/conv_sched.sv
`default_nettype none
// ============================================================================
// Module   : conv_sched
// Brief    : Sliding-window convolution scheduler feeding a K*K-period MAC PE.
// Revision : 1.0 - initial release
// ============================================================================
module conv_sched #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    conv_sched_if.master bus
);
    localparam int c_TAPS   = K * K;
    localparam int c_WA_W   = $clog2(c_TAPS);
    localparam int c_OX_MAX = IMG_W - K;
    localparam int c_OY_MAX = IMG_H - K;

    localparam logic [ADDR_W-1:0] c_IMG_W_A = ADDR_W'(IMG_W);
    localparam logic [c_WA_W-1:0] c_K_LAST  = c_WA_W'(K - 1);
    localparam logic [c_WA_W-1:0] c_K_A     = c_WA_W'(K);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [c_WA_W-1:0] r_kx;
    logic [c_WA_W-1:0] r_ky;
    logic [ADDR_W-1:0] r_ox;
    logic [ADDR_W-1:0] r_oy;
    logic [ADDR_W-1:0] r_win;
    logic [ADDR_W-1:0] r_win_d;
    logic [7:0]        r_bias;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_pe_vld;
    logic              r_last_d;
    logic [7:0]        r_out_data;
    logic [ADDR_W-1:0] r_out_idx;
    logic              r_out_valid;

    logic              w_tap_last;
    logic              w_win_last;
    logic              w_issue;
    logic              w_capture;
    logic              w_misalign;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_in_addr;
    logic [c_WA_W-1:0] w_w_addr;

    assign w_tap_last = (r_kx == c_K_LAST) && (r_ky == c_K_LAST);
    assign w_win_last = (r_ox == ADDR_W'(c_OX_MAX)) && (r_oy == ADDR_W'(c_OY_MAX));

    // The last tap produces a PE result, so it waits until the output slot frees up.
    assign w_issue    = (r_state == c_S_RUN) &&
                        (!w_tap_last || !r_out_valid || bus.out_ready);
    assign w_capture  = r_pe_vld & bus.pe_outmap_vld;
    assign w_misalign = r_pe_vld & (bus.pe_outmap_vld ^ r_last_d);

    assign w_row      = r_oy + ADDR_W'(r_ky);
    assign w_in_addr  = w_row * c_IMG_W_A + r_ox + ADDR_W'(r_kx);
    assign w_w_addr   = r_ky * c_K_A + r_kx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_kx    <= '0;
            r_ky    <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_win   <= '0;
            r_win_d <= '0;
            r_bias  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (bus.start) begin
                        r_bias  <= bus.cfg_bias;
                        r_kx    <= '0;
                        r_ky    <= '0;
                        r_ox    <= '0;
                        r_oy    <= '0;
                        r_win   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_S_RUN;
                    end
                end
                c_S_RUN: begin
                    if (w_issue) begin
                        r_win_d <= r_win;
                        if (r_kx != c_K_LAST) begin
                            r_kx <= r_kx + 1'b1;
                        end else begin
                            r_kx <= '0;
                            if (r_ky != c_K_LAST) begin
                                r_ky <= r_ky + 1'b1;
                            end else begin
                                r_ky  <= '0;
                                r_win <= w_win_last ? '0 : r_win + 1'b1;
                                if (r_ox != ADDR_W'(c_OX_MAX)) begin
                                    r_ox <= r_ox + 1'b1;
                                end else begin
                                    r_ox <= '0;
                                    r_oy <= (r_oy == ADDR_W'(c_OY_MAX)) ? '0 : r_oy + 1'b1;
                                end
                            end
                        end
                        if (w_tap_last && w_win_last) begin
                            r_state <= c_S_DRAIN;
                        end
                    end
                end
                c_S_DRAIN: begin
                    // Final result must have left the PE and been taken downstream.
                    if (!r_pe_vld && (!r_out_valid || bus.out_ready)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pe_vld    <= 1'b0;
            r_last_d    <= 1'b0;
            r_err       <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_pe_vld <= w_issue;
            r_last_d <= w_issue & w_tap_last;
            if (w_misalign) begin
                r_err <= 1'b1;
            end
            if (w_capture) begin
                r_out_data  <= bus.pe_outmap;
                r_out_idx   <= r_win_d;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.in_rd     = w_issue;
    assign bus.w_rd      = w_issue;
    assign bus.in_addr   = w_in_addr;
    assign bus.w_addr    = w_w_addr;
    assign bus.pe_inmap  = bus.in_data;
    assign bus.pe_weight = bus.w_data;
    assign bus.pe_vld    = r_pe_vld;
    assign bus.pe_bias   = r_bias;
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_conv_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_sched
// Brief    : Randomised and directed bench for conv_sched with a behavioural PE.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_sched;
    localparam int c_IMG_W  = 6;
    localparam int c_IMG_H  = 6;
    localparam int c_K      = 5;
    localparam int c_ADDR_W = 10;
    localparam int c_TAPS   = c_K * c_K;
    localparam int c_WA_W   = $clog2(c_TAPS);
    localparam int c_NOX    = c_IMG_W - c_K + 1;
    localparam int c_NOY    = c_IMG_H - c_K + 1;
    localparam int c_NWIN   = c_NOX * c_NOY;
    localparam int c_NPIX   = c_IMG_W * c_IMG_H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_sched_if #(.ADDR_W(c_ADDR_W), .K(c_K)) bus ();

    conv_sched #(
        .IMG_W (c_IMG_W),
        .IMG_H (c_IMG_H),
        .K     (c_K),
        .ADDR_W(c_ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Q4.3 activation: rescale the Q.6 accumulator, add bias, ReLU, saturate.
    function automatic logic [7:0] activate(input int acc, input logic [7:0] bias);
        int s;
        s = (acc >>> 3) + int'($signed(bias));
        if (s < 0)   s = 0;
        if (s > 127) s = 127;
        return s[7:0];
    endfunction

    logic [7:0] img_mem [c_NPIX];
    logic [7:0] wt_mem  [c_TAPS];
    logic [7:0] cur_bias;

    always @(posedge clk) begin
        if (bus.in_rd) bus.in_data <= (int'(bus.in_addr) < c_NPIX) ? img_mem[int'(bus.in_addr)] : 8'h00;
        if (bus.w_rd)  bus.w_data  <= (int'(bus.w_addr) < c_TAPS) ? wt_mem[int'(bus.w_addr)] : 8'h00;
    end

    // PE: counts pe_vld cycles, emits its result alongside the K*K-th product.
    int pe_cnt;
    int pe_acc;
    int pe_prod;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_cnt <= 0;
            pe_acc <= 0;
        end else if (bus.pe_vld) begin
            if (pe_cnt == c_TAPS - 1) begin
                pe_cnt <= 0;
                pe_acc <= 0;
            end else begin
                pe_cnt <= pe_cnt + 1;
                pe_acc <= pe_acc + pe_prod;
            end
        end
    end
    always_comb begin
        pe_prod           = int'($signed(bus.pe_inmap)) * int'($signed(bus.pe_weight));
        bus.pe_outmap_vld = bus.pe_vld && (pe_cnt == c_TAPS - 1);
        bus.pe_outmap     = activate(pe_acc + pe_prod, bus.pe_bias);
    end

    function automatic logic [7:0] ref_pixel(input int ox, input int oy);
        int acc = 0;
        for (int ky = 0; ky < c_K; ky++)
            for (int kx = 0; kx < c_K; kx++)
                acc += int'($signed(img_mem[(oy + ky) * c_IMG_W + ox + kx])) *
                       int'($signed(wt_mem[ky * c_K + kx]));
        return activate(acc, cur_bias);
    endfunction

    int  got_q[$];
    int  iss_q[$];
    int  vld_cnt, done_cnt, rd_mis, stall_seen;
    bit  prev_hold;
    int  prev_val;

    always @(negedge clk) begin
        int cur;
        cur = int'({bus.out_idx, bus.out_data});
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (bus.pe_vld) vld_cnt++;
            if (bus.in_rd != bus.w_rd) rd_mis++;
            if (bus.in_rd) iss_q.push_back(int'({bus.in_addr, bus.w_addr}));
            if (bus.busy && !bus.in_rd && int'(bus.w_addr) == c_TAPS - 1 &&
                bus.out_valid && !bus.out_ready) stall_seen++;
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_value", cur, prev_val);
            end
            if (bus.out_valid && bus.out_ready) got_q.push_back(cur);
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_val  = cur;
            if (bus.done) done_cnt++;
        end
    end

    int ready_mode = 0;
    bit arm = 1'b0;
    int stall_left = 0;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: bus.out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (arm && bus.out_valid) begin
                        arm        = 1'b0;
                        stall_left = 30;
                    end
                    if (stall_left > 0) begin
                        bus.out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        iss_q.delete();
        vld_cnt    = 0;
        done_cnt   = 0;
        rd_mis     = 0;
        stall_seen = 0;
    endtask

    task automatic pulse_start(input logic [7:0] b);
        bus.cfg_bias = b;
        bus.start    = 1'b1;
        tick(1);
        bus.start    = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ":busy"},      32'(bus.busy),      0);
        chk({tag, ":done"},      32'(bus.done),      0);
        chk({tag, ":err"},       32'(bus.err),       0);
        chk({tag, ":in_rd"},     32'(bus.in_rd),     0);
        chk({tag, ":w_rd"},      32'(bus.w_rd),      0);
        chk({tag, ":pe_vld"},    32'(bus.pe_vld),    0);
        chk({tag, ":out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, ":out_data"},  32'(bus.out_data),  0);
        chk({tag, ":out_idx"},   32'(bus.out_idx),   0);
        chk({tag, ":in_addr"},   32'(bus.in_addr),   0);
        chk({tag, ":w_addr"},    32'(bus.w_addr),    0);
        chk({tag, ":pe_bias"},   32'(bus.pe_bias),   0);
    endtask

    task automatic wait_and_check(input string tag);
        bit ok = 1'b0;
        int e0, k;
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if (done_cnt != 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, ":done_seen"}, 32'(ok), 1);
        tick(4);
        chk({tag, ":done_once"}, done_cnt, 1);
        chk({tag, ":busy_idle"}, 32'(bus.busy), 0);
        chk({tag, ":err"},       32'(bus.err), 0);
        chk({tag, ":pe_vld_n"},  vld_cnt, c_TAPS * c_NWIN);
        chk({tag, ":rd_pair"},   rd_mis, 0);
        chk({tag, ":n_out"},     got_q.size(), c_NWIN);
        k = 0;
        for (int oy = 0; oy < c_NOY; oy++)
            for (int ox = 0; ox < c_NOX; ox++) begin
                if (k < got_q.size())
                    chk($sformatf("%s:out%0d", tag, k), got_q[k],
                        ((oy * c_NOX + ox) << 8) | int'(ref_pixel(ox, oy)));
                k++;
            end
        chk({tag, ":n_issue"}, iss_q.size(), c_TAPS * c_NWIN);
        k  = 0;
        e0 = n_err;
        for (int oy = 0; oy < c_NOY; oy++)
            for (int ox = 0; ox < c_NOX; ox++)
                for (int ky = 0; ky < c_K; ky++)
                    for (int kx = 0; kx < c_K; kx++) begin
                        if (k < iss_q.size() && n_err == e0)
                            chk($sformatf("%s:issue%0d", tag, k), iss_q[k],
                                (((oy + ky) * c_IMG_W + ox + kx) << c_WA_W) | (ky * c_K + kx));
                        k++;
                    end
    endtask

    task automatic fill_const(input logic [7:0] px, input logic [7:0] wt);
        for (int i = 0; i < c_NPIX; i++) img_mem[i] = px;
        for (int i = 0; i < c_TAPS; i++) wt_mem[i] = wt;
    endtask

    task automatic run_pass(input string tag, input logic [7:0] b, input int mode);
        cur_bias   = b;
        ready_mode = mode;
        arm        = (mode == 2);
        clear_mon();
        pulse_start(b);
        tick(3);
        chk({tag, ":pe_bias"}, 32'(bus.pe_bias), 32'(b));
        wait_and_check(tag);
    endtask

    initial begin
        int tmp;
        bit hit;
        bus.start    = 1'b0;
        bus.cfg_bias = 8'h00;
        cur_bias     = 8'h00;
        clear_mon();
        #12;
        check_reset_state("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);

        fill_const(8'h08, 8'h01);
        run_pass("basic", 8'h00, 0);
        for (int i = 0; i < got_q.size(); i++) begin
            tmp = got_q[i];
            chk($sformatf("basic:val%0d", i), tmp[7:0], 8'h19);
        end

        run_pass("stall", 8'h00, 2);
        chk("stall:tap24_held", 32'(stall_seen != 0), 1);

        run_pass("bias", 8'hF0, 0);
        for (int i = 0; i < got_q.size(); i++) begin
            tmp = got_q[i];
            chk($sformatf("bias:val%0d", i), tmp[7:0], 8'h09);
        end

        // A second start mid-pass with a different bias must change nothing.
        cur_bias   = 8'h00;
        ready_mode = 0;
        clear_mon();
        pulse_start(8'h00);
        tick(10);
        pulse_start(8'h7F);
        tick(2);
        chk("restart:pe_bias", 32'(bus.pe_bias), 0);
        wait_and_check("restart");

        clear_mon();
        pulse_start(8'h00);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (iss_q.size() >= 40) begin
                hit = 1'b1;
                break;
            end
            tick(1);
        end
        chk("abort:reached40", 32'(hit), 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("abort");
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("abort:no_done", done_cnt, 0);
        run_pass("after_abort", 8'h00, 0);

        for (int i = 0; i < c_NPIX; i++) img_mem[i] = 8'(i);
        for (int i = 0; i < c_TAPS; i++) wt_mem[i] = (i == 12) ? 8'h08 : 8'h00;
        run_pass("ramp", 8'h00, 1);
        for (int i = 0; i < got_q.size(); i++) begin
            tmp = got_q[i];
            chk($sformatf("ramp:centre%0d", i), tmp[7:0],
                (i / c_NOX + 2) * c_IMG_W + (i % c_NOX) + 2);
        end

        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < c_NPIX; i++) img_mem[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < c_TAPS; i++) wt_mem[i] = 8'($urandom_range(0, 16)) - 8'd8;
            run_pass($sformatf("rand%0d", p), 8'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
